// File: rtl/dram_arbiter_if.sv
`timescale 1ns/1ps
// One requester port of dram_arbiter: request/acknowledge transfer bus with read data and stall.
interface dram_arbiter_if #(
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          stall;

    // Handshake: the master raises req with we/addr/wdata and holds them stable until ack is
    // high; ack high in a cycle means the transfer completes at that cycle's closing edge.
    modport master (output req, we, addr, wdata, input ack, rdata, stall);
    modport slave  (input req, we, addr, wdata, output ack, rdata, stall);
endinterface

// File: rtl/dram_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one async-read/sync-write data memory between the core (port 0)
// and a loader/DMA master (port 1), with bounded locked bursts on port 1.
module dram_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dram_arbiter_if.slave   m0,
    dram_arbiter_if.slave   m1,
    input  logic            m1_lock,
    output logic            mem_we,
    output logic [AW-1:0]   mem_a,
    output logic [DW-1:0]   mem_d,
    input  logic [DW-1:0]   mem_spo,
    output logic [1:0]      o_dbg_state
);
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_gnt;
    logic [LW-1:0] r_lock_cnt;
    logic [LW-1:0] w_lock_nxt;
    logic          w_ack0;
    logic          w_ack1;
    logic          w_cand0;
    logic          w_cand1;
    logic          w_locked;
    logic          w_unused_addr;

    assign w_ack0 = (r_state == GNT0) & m0.req;
    assign w_ack1 = (r_state == GNT1) & m1.req;

    assign m0.ack   = w_ack0;
    assign m1.ack   = w_ack1;
    assign m0.rdata = w_ack0 ? mem_spo : '0;
    assign m1.rdata = w_ack1 ? mem_spo : '0;
    assign m0.stall = m0.req & ~w_ack0;
    assign m1.stall = m1.req & ~w_ack1;

    assign o_dbg_state = r_state;

    // Byte-offset bits and address bits above the memory are deliberately dropped.
    assign w_unused_addr = ^{m0.addr[31:AW+2], m0.addr[1:0], m1.addr[31:AW+2], m1.addr[1:0]};

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        case (r_state)
            GNT0: begin
                mem_we = m0.req & m0.we;
                mem_a  = m0.addr[AW+1:2];
                mem_d  = m0.wdata;
            end
            GNT1: begin
                mem_we = m1.req & m1.we;
                mem_a  = m1.addr[AW+1:2];
                mem_d  = m1.wdata;
            end
            default: ;
        endcase
    end

    // A port being acked is not re-granted next cycle, except port 1 holding its lock.
    assign w_cand0  = m0.req & (r_state != GNT0);
    assign w_cand1  = m1.req & ((r_state != GNT1) | m1_lock);
    assign w_locked = (r_state == GNT1) & m1.req & m1_lock;

    always_comb begin
        w_next     = IDLE;
        w_lock_nxt = '0;
        if (w_locked) begin
            w_next = GNT1;
            if (m0.req) begin
                // Port 0 has waited through MAX_LOCK locked grants: break the lock.
                if (r_lock_cnt >= LW'(MAX_LOCK - 1)) begin
                    w_next = GNT0;
                end else begin
                    w_lock_nxt = r_lock_cnt + LW'(1);
                end
            end
        end else if (w_cand0 & w_cand1) begin
            w_next = r_last_gnt ? GNT0 : GNT1;
        end else if (w_cand0) begin
            w_next = GNT0;
        end else if (w_cand1) begin
            w_next = GNT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_lock_cnt <= w_lock_nxt;
            if (w_ack0) begin
                r_last_gnt <= 1'b0;
            end else if (w_ack1) begin
                r_last_gnt <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
// Bench for dram_arbiter: directed scenarios plus random two-master traffic, all checked
// every cycle against a behavioural owner/shadow-memory model.
module tb_dram_arbiter;
    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;
    localparam int MEMW     = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            m1_lock;
    logic            mem_we;
    logic [AW-1:0]   mem_a;
    logic [DW-1:0]   mem_d;
    logic [DW-1:0]   mem_spo;
    logic [1:0]      dbg_state;

    dram_arbiter_if #(.DW(DW)) m0_if ();
    dram_arbiter_if #(.DW(DW)) m1_if ();

    dram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .m1_lock     (m1_lock),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_spo     (mem_spo),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:MEMW-1];
    bit            ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < MEMW; i++) ram[i] <= '0;
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_a] <= mem_d;
        end
    end
    assign mem_spo = ram[mem_a];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
        return AW'(addr >> 2);
    endfunction

    // Model: who owns the memory this cycle (-1 none), who was served last, locked run length.
    int            mdl_owner = -1;
    bit            mdl_last  = 1'b1;
    int            mdl_run   = 0;
    bit            sh_ready  = 1'b0;
    logic [DW-1:0] shadow [0:MEMW-1];
    logic          e_ack0, e_ack1, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_rd0, e_rd1;
    bit            want0, want1, keep1;

    always @(negedge clk) begin
        if (!sh_ready) begin
            for (int i = 0; i < MEMW; i++) shadow[i] = '0;
            sh_ready = 1'b1;
        end
        if (!rst_n) begin
            chk("rst_ack0", m0_if.ack, 0);
            chk("rst_ack1", m1_if.ack, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_a", 32'(mem_a), 0);
            chk("rst_mem_d", mem_d, 0);
            chk("rst_rdata0", m0_if.rdata, 0);
            chk("rst_rdata1", m1_if.rdata, 0);
            mdl_owner = -1;
            mdl_last  = 1'b1;
            mdl_run   = 0;
        end else begin
            e_ack0 = (mdl_owner == 0) && m0_if.req;
            e_ack1 = (mdl_owner == 1) && m1_if.req;
            e_we = 1'b0; e_a = '0; e_d = '0;
            if (mdl_owner == 0) begin
                e_a = word_of(m0_if.addr); e_d = m0_if.wdata; e_we = e_ack0 && m0_if.we;
            end else if (mdl_owner == 1) begin
                e_a = word_of(m1_if.addr); e_d = m1_if.wdata; e_we = e_ack1 && m1_if.we;
            end
            e_rd0 = e_ack0 ? shadow[e_a] : '0;
            e_rd1 = e_ack1 ? shadow[e_a] : '0;
            chk("ack0", m0_if.ack, e_ack0);
            chk("ack1", m1_if.ack, e_ack1);
            chk("stall0", m0_if.stall, m0_if.req && !e_ack0);
            chk("stall1", m1_if.stall, m1_if.req && !e_ack1);
            chk("mem_we", mem_we, e_we);
            chk("mem_a", 32'(mem_a), 32'(e_a));
            chk("mem_d", mem_d, e_d);
            chk("rdata0", m0_if.rdata, e_rd0);
            chk("rdata1", m1_if.rdata, e_rd1);
            if (e_we) shadow[e_a] = e_d;
            if (e_ack0) mdl_last = 1'b0;
            if (e_ack1) mdl_last = 1'b1;
            want0 = m0_if.req && (mdl_owner != 0);
            want1 = m1_if.req && ((mdl_owner != 1) || m1_lock);
            keep1 = (mdl_owner == 1) && m1_if.req && m1_lock;
            if (keep1) begin
                if (m0_if.req) begin
                    mdl_run++;
                    if (mdl_run >= MAX_LOCK) begin
                        mdl_owner = 0;
                        mdl_run   = 0;
                    end
                end else begin
                    mdl_run = 0;
                end
            end else begin
                mdl_run = 0;
                if (want0 && want1) mdl_owner = mdl_last ? 0 : 1;
                else if (want0)     mdl_owner = 0;
                else if (want1)     mdl_owner = 1;
                else                mdl_owner = -1;
            end
        end
    end

    // Ack history, dual-ack and stall counters, port-0 ack snapshot.
    int            ack_log[$];
    int            dual_cnt   = 0;
    int            stall0_cnt = 0;
    logic [AW-1:0] cap_a;
    logic          cap_we;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_if.ack) begin
                ack_log.push_back(0);
                cap_a  = mem_a;
                cap_we = mem_we;
            end
            if (m1_if.ack) ack_log.push_back(1);
            if (m0_if.ack && m1_if.ack) dual_cnt++;
            if (m0_if.stall) stall0_cnt++;
        end
    end

    logic [31:0] exp_q[$];

    task automatic sb_check(input string name, input logic [31:0] got);
        logic [31:0] e;
        e = exp_q.pop_front();
        chk(name, got, e);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input bit lock);
        if (p == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = data;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = data;
            m1_lock = lock;
        end
    endtask

    // Called just after a rising edge; returns just after the edge closing the ack cycle.
    task automatic xfer(input int p, input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input bit lock, output int lat, output logic [31:0] rd);
        bit got;
        int waited;
        got = 1'b0; waited = 0; lat = 0; rd = '0;
        drive(p, 1'b1, we, addr, data, lock);
        while (!got && waited < 200) begin
            @(negedge clk);
            if ((p == 0) ? m0_if.ack : m1_if.ack) begin
                got = 1'b1;
                rd  = (p == 0) ? m0_if.rdata : m1_if.rdata;
            end
            @(posedge clk);
            #1;
            if (!got) lat++;
            waited++;
        end
        chk($sformatf("xfer_ack_p%0d", p), 32'(got), 1);
        drive(p, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_master(input int p, input int n);
        int          cnt, gap, burst, lat;
        bit          lk;
        logic [31:0] rd, addr;
        cnt = 0;
        while (cnt < n) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            burst = 1; lk = 1'b0;
            if (p == 1 && $urandom_range(0, 3) == 0) begin
                burst = $urandom_range(2, 8);
                lk    = 1'b1;
            end
            for (int k = 0; k < burst; k++) begin
                addr = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 20);
                xfer(p, 1'($urandom_range(0, 1)), addr, $urandom, lk, lat, rd);
                cnt++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int          lat0, lat1, base, s0, d0, mism;
    logic [31:0] rd0, rd1;
    int          t3_exp, t5_exp[9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);

        // Reset holds everything at zero; idle after release.
        repeat (3) @(negedge clk);
        chk("t1_rst_mem_we", mem_we, 0);
        chk("t1_rst_ack0", m0_if.ack, 0);
        chk("t1_rst_mem_d", mem_d, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t1_idle_mem_we", mem_we, 0);
        chk("t1_idle_ack1", m1_if.ack, 0);

        // Port 0 write then read back.
        s0 = stall0_cnt;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat0, rd0);
        chk("t2_wr_lat", lat0, 1);
        chk("t2_wr_mem_a", 32'(cap_a), 4);
        chk("t2_wr_mem_we", 32'(cap_we), 1);
        chk("t2_wr_stall", stall0_cnt - s0, 1);
        chk("t2_ram", ram[4], 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        xfer(0, 1'b0, 32'h10, '0, 1'b0, lat0, rd0);
        chk("t2_rd_lat", lat0, 1);
        sb_check("t2_rd_data", rd0);

        // Last served was port 0, so a simultaneous request goes to port 1 first.
        base = ack_log.size();
        exp_q.push_back(32'h1234);
        fork
            xfer(0, 1'b0, 32'h20, '0, 1'b0, lat0, rd0);
            xfer(1, 1'b1, 32'h20, 32'h1234, 1'b0, lat1, rd1);
        join
        chk("t4_count", ack_log.size() - base, 2);
        chk("t4_first", (ack_log.size() > base) ? ack_log[base] : -1, 1);
        chk("t4_second", (ack_log.size() > base + 1) ? ack_log[base + 1] : -1, 0);
        sb_check("t4_rd_data", rd0);

        // Both ports requesting continuously from reset: strict alternation, port 0 first.
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, '0, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h4, '0, 1'b0);
        @(posedge clk); #1;
        base = ack_log.size();
        d0   = dual_cnt;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("t3_enough_acks", 32'(ack_log.size() - base >= 8), 1);
        for (int i = 0; i < 8; i++) begin
            t3_exp = i % 2;
            chk($sformatf("t3_order_%0d", i), (ack_log.size() > base + i) ? ack_log[base + i] : -1, t3_exp);
        end
        chk("t3_dual", dual_cnt - d0, 0);

        // Locked port-1 burst of 8; port 0 waits exactly MAX_LOCK grants.
        do_reset();
        base = ack_log.size();
        s0   = stall0_cnt;
        exp_q.push_back(32'h50);
        fork
            begin
                for (int k = 0; k < 8; k++)
                    xfer(1, 1'b1, 32'h100 + 32'(4 * k), 32'h50 + 32'(k), 1'b1, lat1, rd1);
            end
            begin
                int w = 0;
                while (ack_log.size() < base + 2 && w < 100) begin
                    @(negedge clk); #1;
                    w++;
                end
                @(posedge clk); #1;
                xfer(0, 1'b0, 32'h100, '0, 1'b0, lat0, rd0);
            end
        join
        chk("t5_count", ack_log.size() - base, 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t5_order_%0d", i), (ack_log.size() > base + i) ? ack_log[base + i] : -1, t5_exp[i]);
        chk("t5_stall", stall0_cnt - s0, 4);
        sb_check("t5_rd_data", rd0);

        // Reset during a port-1 write: write dropped immediately.
        do_reset();
        base = ack_log.size();
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0);
        @(posedge clk); #1;
        chk("t6_gnt_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_ack1", m1_if.ack, 0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("t6_ram_kept", ram[16], 0);
        chk("t6_no_ack", ack_log.size() - base, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, lat1, rd1);
        chk("t6_reissue_ram", ram[16], 32'hA5A5A5A5);

        // Random concurrent traffic.
        fork
            rand_master(0, 150);
            rand_master(1, 150);
        join
        repeat (3) @(posedge clk); #1;
        mism = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== shadow[i]) mism++;
        chk("final_mem", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
